// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stall FSM encoding and the x0 index.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MULDIV  = 2'd1,
    ST_MEMWAIT = 2'd2
  } stall_state_t;

  // Architectural zero register; never a real producer.
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector: EX load whose destination is read by the ID instruction.
import pipe_pkg::*;

module hazard_cmp (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  // x0 never carries a dependency, so it cannot cause a stall.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller.
// Optional feature: define STALL_MULDIV_EN to build the multi-cycle mul/div
// stall sequence (MULDIV state and its down-counter); otherwise ex_muldiv is
// ignored and muldiv_busy is tied low.
import pipe_pkg::*;

module stall_ctrl #(
  parameter int MULDIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_muldiv,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        muldiv_busy,
  output logic [31:0] stall_cycles
);

  stall_state_t state, state_nx;
  logic load_use;
  logic mem_wait;

  hazard_cmp u_hazard_cmp (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_mem_read(ex_mem_read),
    .load_use   (load_use)
  );

  assign mem_wait = mem_req && !mem_ready;

`ifdef STALL_MULDIV_EN
  logic [5:0] cnt, cnt_nx, cnt_dec;

  assign cnt_dec = cnt - 6'd1;

  // Down-counter for the mul/div sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 6'd0;
    else      cnt <= cnt_nx;
  end

  assign muldiv_busy = rst && (state == ST_MULDIV);
`else
  logic unused_muldiv;
  assign unused_muldiv = ex_muldiv | (MULDIV_LAT < 2);
  assign muldiv_busy   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nx;
  end

  // Next state and hold/flush outputs, highest-priority event first.
  always_comb begin
    state_nx    = state;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
`ifdef STALL_MULDIV_EN
    cnt_nx      = cnt;
`endif
    if (mem_wait) begin
      // Freeze everything up to MEM; a bubble goes down to WB.
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_hold   = 1'b1;
      exmem_hold  = 1'b1;
      memwb_flush = 1'b1;
      if (state == ST_RUN) state_nx = ST_MEMWAIT;
`ifdef STALL_MULDIV_EN
    end else if (state == ST_MULDIV) begin
      // The entry cycle is the first of the MULDIV_LAT-1 stall cycles, so
      // the sequence releases on the cycle the count drains to zero.
      cnt_nx = cnt_dec;
      if (cnt_dec == 6'd0) begin
        state_nx = ST_RUN;
      end else begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_hold = 1'b1;
      end
    end else if (ex_muldiv) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      idex_hold = 1'b1;
      cnt_nx    = 6'(MULDIV_LAT - 1);
      state_nx  = ST_MULDIV;
`endif
    end else begin
      // RUN, or the cycle MEMWAIT sees its memory complete.
      state_nx = ST_RUN;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end
    end
    if (!rst) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      idex_hold   = 1'b0;
      exmem_hold  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
    end
  end

  // Stall cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         stall_cycles <= 32'd0;
    else if (pc_hold) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: stimulus pushes expected outputs from a
// behavioural model, an independent monitor pops and compares every cycle.
module tb_stall_ctrl;

  localparam int LAT = 32;
`ifdef STALL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_muldiv = 0;
  logic        ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic        pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic        ifid_flush, idex_flush, memwb_flush, muldiv_busy;
  logic [31:0] stall_cycles;

  stall_ctrl #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] ex_rd;
    logic       mr, md, br, mreq, mrdy;
  } stim_t;

  typedef struct {
    logic [7:0]  outs;  // pc,ifid,idex,exmem hold; ifid,idex,memwb flush; busy
    logic [31:0] stall;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: a mul/div occupies LAT-1 busy cycles after the entry
  // cycle; the last busy cycle stalls nothing. Memory wait freezes progress.
  bit          m_busy = 0;
  int          m_left = 0;
  logic [31:0] m_stall = '0;

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    logic [7:0] o;
    bit wt, lu;
    @(negedge clk);
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    ex_rd = s.ex_rd; ex_mem_read = s.mr; ex_muldiv = s.md; ex_branch_taken = s.br;
    mem_req = s.mreq; mem_ready = s.mrdy;
    o = '0;
    if (!s.rst) begin
      m_busy = 0; m_left = 0; m_stall = '0;
      e.stall = '0;
    end else begin
      e.stall = m_stall;
      o[0] = m_busy;
      wt = s.mreq && !s.mrdy;
      lu = s.mr && (s.ex_rd != 0) &&
           ((s.u1 && s.rs1 == s.ex_rd) || (s.u2 && s.rs2 == s.ex_rd));
      if (wt) begin
        o[7:4] = 4'b1111; o[1] = 1'b1;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
        else o[7:5] = 3'b111;
      end else if (MD_EN && s.md) begin
        o[7:5] = 3'b111; m_busy = 1; m_left = LAT - 1;
      end else if (s.br) begin
        o[3:2] = 2'b11;
      end else if (lu) begin
        o[7] = 1'b1; o[6] = 1'b1; o[2] = 1'b1;
      end
      if (o[7]) m_stall = m_stall + 32'd1;
    end
    e.outs = o;
    q.push_back(e);
  endtask

  // Monitor: DUT presents a result every cycle; compare late in the cycle.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_hold, ifid_hold, idex_hold, exmem_hold,
               ifid_flush, idex_flush, memwb_flush, muldiv_busy};
        n_chk++;
        if (act !== e.outs) begin
          n_fail++;
          $display("FAIL outs t=%0t got=%b expected=%b", $time, act, e.outs);
        end
        n_chk++;
        if (stall_cycles !== e.stall) begin
          n_fail++;
          $display("FAIL stall_cycles t=%0t got=%0d expected=%0d", $time, stall_cycles, e.stall);
        end
      end
    end
  end

  initial begin
    stim_t s;
    // Reset state
    s = idle(); s.rst = 1'b0;
    repeat (2) drive(s);
    s = idle();
    repeat (2) drive(s);
    // Load-use on rs2, then the same with x0 as destination
    s = idle(); s.mr = 1; s.ex_rd = 5; s.rs2 = 5; s.u2 = 1;
    drive(s);
    drive(idle());
    s.ex_rd = 0; s.rs2 = 0;
    drive(s);
    // Taken branch discards a coincident load-use
    s = idle(); s.mr = 1; s.ex_rd = 5; s.rs2 = 5; s.u2 = 1; s.br = 1;
    drive(s);
    // Mul/div pulse with a 3-cycle memory wait in the middle
    s = idle(); s.md = 1;
    drive(s);
    repeat (10) drive(idle());
    s = idle(); s.mreq = 1; s.mrdy = 0;
    repeat (3) drive(s);
    repeat (LAT + 3) drive(idle());
    // Reset in the middle of a memory wait
    s = idle(); s.mreq = 1;
    repeat (2) drive(s);
    s.rst = 1'b0;
    drive(s);
    s = idle(); s.mreq = 1; s.mrdy = 1;
    drive(s);
    drive(idle());
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(0, 299) != 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.ex_rd = 5'($urandom_range(0, 3));
      s.mr    = 1'($urandom_range(0, 1));
      s.md    = ($urandom_range(0, 39) == 0);
      s.br    = ($urandom_range(0, 5) == 0);
      s.mreq  = ($urandom_range(0, 2) == 0);
      s.mrdy  = 1'($urandom_range(0, 1));
      drive(s);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MULDIV_LAT, default 32: EX-stage cycles a mul/div occupies; legal range 2..63.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 id_rs1, id_rs2  in  5 each  ID-stage source register indices.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-006 ex_rd  in  5  EX-stage destination index; ex_mem_read  in  1  EX instruction is a load.
REQ-007 ex_muldiv  in  1  EX instruction is a mul/div (level, valid while in EX).
REQ-008 ex_branch_taken  in  1  EX resolved a taken branch/jump.
REQ-009 mem_req  in  1  MEM stage accessing data memory; mem_ready  in  1  data memory completes this cycle.
REQ-010 pc_hold, ifid_hold, idex_hold, exmem_hold  out  1 each  1 = freeze that stage register (drives its active-high en, which holds Q).
REQ-011 ifid_flush, idex_flush, memwb_flush  out  1 each  1 = load a bubble (register rst) on next edge.
REQ-012 muldiv_busy  out  1  mul/div sequence in progress; stall_cycles  out  32  count of cycles with pc_hold=1.

Function
REQ-013 FSM states SHALL be RUN, MULDIV, MEMWAIT; hold/flush outputs SHALL be combinational from state and inputs.
REQ-014 Load-use SHALL be: ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-015 Priority per cycle SHALL be: memory wait > mul/div > taken branch > load-use.
REQ-016 Memory wait (mem_req & ~mem_ready), in any state: pc/ifid/idex/exmem_hold=1, memwb_flush=1, other flushes 0; from RUN go to MEMWAIT, from MULDIV stay and freeze the counter.
REQ-017 MEMWAIT SHALL return to RUN on the first cycle mem_ready=1; that cycle no hold from the memory condition.
REQ-018 RUN with ex_muldiv=1 SHALL load counter with MULDIV_LAT-1 and enter MULDIV; pc/ifid/idex_hold=1, memwb_flush=0, exmem_hold=0; same outputs every MULDIV cycle.
REQ-019 MULDIV SHALL decrement each non-memory-wait cycle; counter==0 releases holds that cycle and returns to RUN; total stall exactly MULDIV_LAT-1 cycles.
REQ-020 muldiv_busy SHALL equal (state==MULDIV).
REQ-021 Taken branch in RUN: ifid_flush=1, idex_flush=1, no holds; a coincident load-use is discarded.
REQ-022 Load-use in RUN (no higher event): pc_hold=1, ifid_hold=1, idex_flush=1 for exactly one cycle; no state change.
REQ-023 stall_cycles SHALL increment when pc_hold=1, wrapping 0xFFFFFFFF->0.
REQ-024 ex_rd==0 SHALL never produce a load-use stall.

Reset
REQ-025 rst=0 SHALL set state RUN, counter 0, stall_cycles 0; all hold/flush outputs and muldiv_busy read 0 while rst=0.
REQ-026 Reset during MULDIV or MEMWAIT SHALL abort the sequence; first cycle after release behaves as RUN.

Configuration
REQ-027 Macro STALL_MULDIV_EN defined: MULDIV state, counter, and REQ-018..020 present.
REQ-028 Macro absent: ex_muldiv ignored, MULDIV state and counter not built, muldiv_busy tied 0; all else unchanged.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the FSM state encoding (2 bits) and the REG_X0 constant 5'd0.
REQ-030 One sub-module hazard_cmp SHALL implement the combinational REQ-014 comparison; the FSM and counters stay in stall_ctrl.

Verification
REQ-031 ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle pc_hold=ifid_hold=idex_flush=1; stall_cycles 0->1.
REQ-032 Same as REQ-031 but ex_rd=0 -> no holds, no flush.
REQ-033 MULDIV_LAT=32, ex_muldiv pulse in RUN -> muldiv_busy high 31 cycles, pc_hold high 31 cycles, then RUN.
REQ-034 mem_req=1, mem_ready=0 for 3 cycles during MULDIV -> all four holds and memwb_flush for 3 cycles, counter frozen, MULDIV total extends by 3.
REQ-035 ex_branch_taken=1 together with load-use -> ifid_flush=idex_flush=1, pc_hold=0.
REQ-036 rst=0 asserted mid-MEMWAIT, released -> outputs 0 immediately, state RUN, stall_cycles 0.
